// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine round sequencer.
// Holds the state encodings that also drive the LCD screen select.
package slot_pkg;

    localparam int STATE_W  = 3;
    localparam int CREDIT_W = 7;

    localparam logic [3:0] JACKPOT_DIGIT = 4'd7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_SPIN   = 3'd2,
        ST_STOP_A = 3'd3,
        ST_STOP_B = 3'd4,
        ST_EVAL   = 3'd5
    } state_t;

endpackage

// File: rtl/slot_credit_ctr.sv
// Saturating coin-credit register.
// Adds coins and payouts and removes one credit per accepted play, clamping at MAX_CREDIT.
module slot_credit_ctr
    import slot_pkg::*;
#(
    parameter int MAX_CREDIT = 99
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                inc,
    input  logic                dec,
    input  logic [4:0]          add_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] credit_next
);

    localparam logic [7:0] MAX_SUM = 8'(MAX_CREDIT);

    logic [7:0] sum;

    // Eight bits hold 127 + 1 + 31 without wrapping; dec never exceeds credit.
    always_comb begin
        sum         = {1'b0, credit} + {7'd0, inc} - {7'd0, dec} + {3'd0, add_amt};
        credit_next = (sum > MAX_SUM) ? MAX_SUM[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            credit <= '0;
        end else begin
            credit <= credit_next;
        end
    end

endmodule

// File: rtl/slot_round_ctrl.sv
// Round sequencer: takes coins, starts a play, releases and stops the three reels in turn,
// then scores the frozen digits and credits the payout.
module slot_round_ctrl
    import slot_pkg::*;
#(
    parameter int SPIN_TICKS  = 150,
    parameter int STOP_GAP    = 50,
    parameter int MAX_CREDIT  = 99,
    parameter int PAY_PAIR    = 2,
    parameter int PAY_TRIPLE  = 10,
    parameter int PAY_JACKPOT = 20
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                C_IN,
    input  logic                GAME_START,
    input  logic [3:0]          REEL0,
    input  logic [3:0]          REEL1,
    input  logic [3:0]          REEL2,
    output logic [2:0]          STOP,
    output logic [CREDIT_W-1:0] CREDIT,
    output logic [STATE_W-1:0]  STATE,
    output logic                WIN,
    output logic [4:0]          WIN_AMT
);

    localparam logic [15:0] SPIN_LAST = 16'(SPIN_TICKS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(STOP_GAP - 1);

    state_t              state;
    logic [15:0]         tick;
    logic                accept;
    logic [4:0]          payout;
    logic [CREDIT_W-1:0] credit_next;

    function automatic logic [4:0] score(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c);
        if (a == JACKPOT_DIGIT && b == JACKPOT_DIGIT && c == JACKPOT_DIGIT)
            return 5'(PAY_JACKPOT);
        else if (a == b && b == c)
            return 5'(PAY_TRIPLE);
        else if (a == b || b == c || a == c)
            return 5'(PAY_PAIR);
        else
            return 5'd0;
    endfunction

    // The credit guard is redundant in READY but keeps underflow impossible by construction.
    assign accept = (state == ST_READY) && GAME_START && (CREDIT != '0);
    assign payout = (state == ST_EVAL) ? score(REEL0, REEL1, REEL2) : 5'd0;
    assign STATE  = state;

    slot_credit_ctr #(
        .MAX_CREDIT(MAX_CREDIT)
    ) u_credit (
        .CLK        (CLK),
        .RST        (RST),
        .inc        (C_IN),
        .dec        (accept),
        .add_amt    (payout),
        .credit     (CREDIT),
        .credit_next(credit_next)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            tick    <= '0;
            STOP    <= 3'b111;
            WIN     <= 1'b0;
            WIN_AMT <= 5'd0;
        end else begin
            WIN <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (CREDIT != '0)
                        state <= ST_READY;
                end
                ST_READY: begin
                    if (accept) begin
                        state <= ST_SPIN;
                        STOP  <= 3'b000;
                        tick  <= '0;
                    end
                end
                ST_SPIN: begin
                    if (tick == SPIN_LAST) begin
                        state <= ST_STOP_A;
                        STOP  <= 3'b001;
                        tick  <= '0;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                ST_STOP_A: begin
                    if (tick == GAP_LAST) begin
                        state <= ST_STOP_B;
                        STOP  <= 3'b011;
                        tick  <= '0;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                ST_STOP_B: begin
                    if (tick == GAP_LAST) begin
                        state <= ST_EVAL;
                        STOP  <= 3'b111;
                        tick  <= '0;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                ST_EVAL: begin
                    WIN_AMT <= payout;
                    WIN     <= (payout != 5'd0);
                    state   <= (credit_next != '0) ? ST_READY : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    STOP  <= 3'b111;
                    tick  <= '0;
                end
            endcase
        end
    end

endmodule
